// File: rtl/beat_ctrl_pkg.sv
// Shared types for the beat sequencer: FSM state encoding and sample width.
package beat_ctrl_pkg;

    localparam int STATE_W  = 3;
    localparam int SAMPLE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_ARM     = 3'd2,
        ST_LISTEN  = 3'd3,
        ST_REFRACT = 3'd4,
        ST_ALARM   = 3'd5
    } beat_state_e;

endpackage

// File: rtl/beat_ctrl_if.sv
// Sequencer-to-filter link: reset/threshold strobes, mode, held sample and peak return.
interface beat_ctrl_if;
    import beat_ctrl_pkg::*;

    logic                flt_reset;
    logic                flt_threshold;
    logic                flt_higher;
    logic [SAMPLE_W-1:0] flt_in;
    logic                flt_peak;

    modport master (
        output flt_reset,
        output flt_threshold,
        output flt_higher,
        output flt_in,
        input  flt_peak
    );

    modport slave (
        input  flt_reset,
        input  flt_threshold,
        input  flt_higher,
        input  flt_in,
        output flt_peak
    );

endinterface

// File: rtl/beat_tick_gen.sv
// Sample-tick divider: one-clock tick every TICK_DIV clocks while run is high.
module beat_tick_gen #(
    parameter int TICK_DIV = 1000,
    parameter int DIV_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (!run || (div == DIV_LAST)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Gated by run so the clock that leaves the running states cannot tick.
    assign tick = run && (div == DIV_LAST);

endmodule

// File: rtl/beat_ctrl.sv
// Sequencer for the threshold/peak filter: reset/threshold strobes, tick-rate sampling,
// refractory beat qualification, beat-to-beat interval measurement and missing-beat alarm.
module beat_ctrl
    import beat_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int DIV_W    = 16,
    parameter int INT_W    = 12,
    parameter int RST_CYC  = 4,
    parameter int REFRACT  = 20,
    parameter int TIMEOUT  = 300
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                higher_sel,
    beat_ctrl_if.master         flt,
    output logic                beat,
    output logic [INT_W-1:0]    interval,
    output logic                interval_valid,
    output logic                alarm,
    output logic [STATE_W-1:0]  state_o
);

    localparam int               RC_W      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [INT_W-1:0] REFRACT_V = INT_W'(REFRACT);
    localparam logic [INT_W-1:0] TIMEOUT_V = INT_W'(TIMEOUT);

    if ((TICK_DIV < 2) || (TICK_DIV > 2**DIV_W) || (RST_CYC < 1) || (REFRACT < 1) ||
        (TIMEOUT <= REFRACT) || (TIMEOUT > 2**INT_W - 1)) begin : g_param_check
        $error("beat_ctrl: parameter set does not fit the counter widths");
    end

    function automatic logic [INT_W-1:0] sat_inc(input logic [INT_W-1:0] v);
        return (v == {INT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    beat_state_e         state, state_next;
    logic [RC_W-1:0]     rst_cnt, rst_cnt_next;
    logic [INT_W-1:0]    ictr, ictr_inc, ictr_next;
    logic                first_flag, first_next;
    logic                beat_next, ivld_next, alarm_next;
    logic [INT_W-1:0]    interval_next;
    logic                freset_next, thr_next;
    logic                flt_reset_q, flt_thr_q, flt_higher_q;
    logic [SAMPLE_W-1:0] flt_in_q;
    logic                pk_d, peak_ev;
    logic                run, tick;

    assign run = enable && (state != ST_IDLE);

    beat_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    assign peak_ev  = flt.flt_peak & ~pk_d;
    // Tick-relative decisions use the count including this clock's tick.
    assign ictr_inc = tick ? sat_inc(ictr) : ictr;

    always_comb begin
        state_next    = state;
        rst_cnt_next  = '0;
        ictr_next     = ictr_inc;
        first_next    = first_flag;
        beat_next     = 1'b0;
        ivld_next     = 1'b0;
        alarm_next    = alarm;
        interval_next = interval;

        unique case (state)
            ST_IDLE: begin
                ictr_next  = '0;
                alarm_next = 1'b0;
                if (enable) state_next = ST_RST;
            end
            ST_RST: begin
                rst_cnt_next = rst_cnt + 1'b1;
                if (rst_cnt == RST_LAST) state_next = ST_ARM;
            end
            ST_ARM: begin
                first_next = 1'b1;
                state_next = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (peak_ev) begin
                    beat_next = 1'b1;
                    if (!first_flag) begin
                        interval_next = ictr_inc;
                        ivld_next     = 1'b1;
                    end
                    first_next = 1'b0;
                    ictr_next  = '0;
                    alarm_next = 1'b0;
                    state_next = ST_REFRACT;
                end else if (tick && (ictr_inc == TIMEOUT_V)) begin
                    alarm_next = 1'b1;
                    state_next = ST_ALARM;
                end
            end
            ST_REFRACT: begin
                if (tick && (ictr_inc == REFRACT_V)) state_next = ST_LISTEN;
            end
            ST_ALARM: begin
                if (peak_ev) begin
                    beat_next  = 1'b1;
                    alarm_next = 1'b0;
                    first_next = 1'b0;
                    ictr_next  = '0;
                    state_next = ST_REFRACT;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Dropping enable aborts everything except the last measured interval.
        if (!enable && (state != ST_IDLE)) begin
            state_next    = ST_IDLE;
            beat_next     = 1'b0;
            ivld_next     = 1'b0;
            alarm_next    = 1'b0;
            first_next    = 1'b0;
            ictr_next     = '0;
            interval_next = interval;
        end

        if ((state == ST_ARM) || (state_next == ST_ARM)) ictr_next = '0;

        freset_next = (state_next == ST_IDLE) || (state_next == ST_RST);
        thr_next    = (state_next == ST_ARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rst_cnt        <= '0;
            ictr           <= '0;
            first_flag     <= 1'b0;
            beat           <= 1'b0;
            interval_valid <= 1'b0;
            interval       <= '0;
            alarm          <= 1'b0;
            flt_reset_q    <= 1'b1;
            flt_thr_q      <= 1'b0;
        end else begin
            state          <= state_next;
            rst_cnt        <= rst_cnt_next;
            ictr           <= ictr_next;
            first_flag     <= first_next;
            beat           <= beat_next;
            interval_valid <= ivld_next;
            interval       <= interval_next;
            alarm          <= alarm_next;
            flt_reset_q    <= freset_next;
            flt_thr_q      <= thr_next;
        end
    end

    // Input-side registers: peak edge history, sample-and-hold, frozen compare mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_d         <= 1'b0;
            flt_in_q     <= '0;
            flt_higher_q <= 1'b0;
        end else begin
            pk_d <= flt.flt_peak;
            if (tick) flt_in_q <= sample_in;
            if ((state == ST_IDLE) || (state == ST_RST)) flt_higher_q <= higher_sel;
        end
    end

    assign flt.flt_reset     = flt_reset_q;
    assign flt.flt_threshold = flt_thr_q;
    assign flt.flt_higher    = flt_higher_q;
    assign flt.flt_in        = flt_in_q;
    assign state_o           = state;

endmodule

// File: tb/tb_beat_ctrl.sv
// Directed bench for beat_ctrl with a beat scoreboard: stimulus queues expected beats,
// a negedge monitor pops and compares whenever beat or interval_valid is seen.
module tb_beat_ctrl;
    import beat_ctrl_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 16;
    localparam int INT_W    = 8;
    localparam int RST_CYC  = 2;
    localparam int REFRACT  = 3;
    localparam int TIMEOUT  = 10;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             enable     = 1'b0;
    logic             higher_sel = 1'b1;
    logic [2:0]       sample_in  = 3'd0;
    logic             beat, interval_valid, alarm;
    logic [INT_W-1:0] interval;
    logic [2:0]       state_o;

    beat_ctrl_if flt_bus();

    beat_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W),
        .INT_W    (INT_W),
        .RST_CYC  (RST_CYC),
        .REFRACT  (REFRACT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_in      (sample_in),
        .higher_sel     (higher_sel),
        .flt            (flt_bus),
        .beat           (beat),
        .interval       (interval),
        .interval_valid (interval_valid),
        .alarm          (alarm),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int c0, c1;

    typedef struct {
        string tag;
        int    ivld;
        int    ival;
        int    alm;
        int    st;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input string tag, input int ivld, input int ival, input int alm, input int st);
        exp_t e;
        e.tag  = tag;
        e.ivld = ivld;
        e.ival = ival;
        e.alm  = alm;
        e.st   = st;
        exp_q.push_back(e);
    endtask

    // Returns #1 after the posedge that brings cyc to target.
    task automatic at_edge(input int target);
        if (cyc > target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: cycle %0d already past target %0d", cyc, target);
        end
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_peak();
        flt_bus.flt_peak = 1'b1;
        @(posedge clk);
        #1;
        flt_bus.flt_peak = 1'b0;
    endtask

    function automatic int fexp(input int k);
        return (3 * k + 1) % 8;
    endfunction

    // sample_in changes every clock; value during the cycle after edge k is fexp(k).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sample_in = 3'(fexp(cyc));
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (beat || interval_valid)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got beat=%0d interval_valid=%0d at cycle %0d, expected none",
                             beat, interval_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.tag, ".beat"},           32'(beat),           1);
                    chk({e.tag, ".interval_valid"}, 32'(interval_valid), e.ivld);
                    chk({e.tag, ".interval"},       32'(interval),       e.ival);
                    chk({e.tag, ".alarm"},          32'(alarm),          e.alm);
                    chk({e.tag, ".state"},          32'(state_o),        e.st);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        flt_bus.flt_peak = 1'b0;

        @(posedge clk);
        #1;
        chk("rst.state",          32'(state_o),               0);
        chk("rst.flt_reset",      32'(flt_bus.flt_reset),     1);
        chk("rst.flt_threshold",  32'(flt_bus.flt_threshold), 0);
        chk("rst.flt_higher",     32'(flt_bus.flt_higher),    0);
        chk("rst.flt_in",         32'(flt_bus.flt_in),        0);
        chk("rst.beat",           32'(beat),                  0);
        chk("rst.interval_valid", 32'(interval_valid),        0);
        chk("rst.interval",       32'(interval),              0);
        chk("rst.alarm",          32'(alarm),                 0);
        #3;
        rst_n = 1'b1;

        at_edge(cyc + 2);
        chk("idle.state",      32'(state_o),           0);
        chk("idle.flt_reset",  32'(flt_bus.flt_reset), 1);
        chk("idle.flt_higher", 32'(flt_bus.flt_higher), 1);

        enable = 1'b1;
        c0 = cyc + 1;

        at_edge(c0 + 0);
        chk("seq0.state",         32'(state_o),               1);
        chk("seq0.flt_reset",     32'(flt_bus.flt_reset),     1);
        chk("seq0.flt_threshold", 32'(flt_bus.flt_threshold), 0);
        at_edge(c0 + 1);
        chk("seq1.state",         32'(state_o),               1);
        chk("seq1.flt_reset",     32'(flt_bus.flt_reset),     1);
        chk("seq1.flt_threshold", 32'(flt_bus.flt_threshold), 0);
        at_edge(c0 + 2);
        chk("seq2.state",         32'(state_o),               2);
        chk("seq2.flt_reset",     32'(flt_bus.flt_reset),     0);
        chk("seq2.flt_threshold", 32'(flt_bus.flt_threshold), 1);
        at_edge(c0 + 3);
        chk("seq3.state",         32'(state_o),               3);
        chk("seq3.flt_threshold", 32'(flt_bus.flt_threshold), 0);
        chk("seq3.flt_higher",    32'(flt_bus.flt_higher),    1);

        at_edge(c0 + 5);
        higher_sel = 1'b0;

        at_edge(c0 + 12);
        chk("hold12.flt_in", 32'(flt_bus.flt_in), fexp(c0 + 11));
        at_edge(c0 + 13);
        chk("hold13.flt_in", 32'(flt_bus.flt_in), fexp(c0 + 11));
        at_edge(c0 + 15);
        chk("hold15.flt_in", 32'(flt_bus.flt_in), fexp(c0 + 11));
        at_edge(c0 + 16);
        chk("load16.flt_in",     32'(flt_bus.flt_in),     fexp(c0 + 15));
        chk("run.flt_higher",    32'(flt_bus.flt_higher), 1);

        push_exp("beat1", 0, 0, 0, 4);
        at_edge(c0 + 21);
        pulse_peak();

        push_exp("beat2", 1, 7, 0, 4);
        at_edge(c0 + 49);
        pulse_peak();

        at_edge(c0 + 51);
        chk("beat2_after.beat",           32'(beat),           0);
        chk("beat2_after.interval_valid", 32'(interval_valid), 0);
        chk("beat2_after.interval",       32'(interval),       7);

        pulse_peak();
        at_edge(c0 + 59);
        pulse_peak();
        at_edge(c0 + 61);
        chk("refract_exit.state", 32'(state_o), 3);

        push_exp("beat3", 1, 5, 0, 4);
        at_edge(c0 + 69);
        pulse_peak();

        at_edge(c0 + 107);
        chk("pre_timeout.alarm", 32'(alarm),   0);
        chk("pre_timeout.state", 32'(state_o), 3);
        at_edge(c0 + 108);
        chk("timeout.alarm", 32'(alarm),   1);
        chk("timeout.state", 32'(state_o), 5);

        push_exp("alarm_beat", 0, 5, 0, 4);
        at_edge(c0 + 113);
        pulse_peak();

        at_edge(c0 + 116);
        enable = 1'b0;
        at_edge(c0 + 117);
        chk("disable.state",         32'(state_o),               0);
        chk("disable.flt_reset",     32'(flt_bus.flt_reset),     1);
        chk("disable.alarm",         32'(alarm),                 0);
        chk("disable.interval",      32'(interval),              5);
        chk("disable.flt_threshold", 32'(flt_bus.flt_threshold), 0);
        at_edge(c0 + 120);
        chk("idle2.flt_in",     32'(flt_bus.flt_in),     fexp(c0 + 115));
        chk("idle2.flt_higher", 32'(flt_bus.flt_higher), 0);
        chk("idle2.interval",   32'(interval),           5);

        enable = 1'b1;
        c1 = cyc + 1;
        at_edge(c1 + 2);
        chk("rearm.state",         32'(state_o),               2);
        chk("rearm.flt_threshold", 32'(flt_bus.flt_threshold), 1);
        at_edge(c1 + 3);
        chk("relisten.state", 32'(state_o), 3);

        push_exp("tie", 0, 5, 0, 4);
        at_edge(c1 + 39);
        pulse_peak();
        at_edge(c1 + 41);
        chk("tie_after.alarm", 32'(alarm),   0);
        chk("tie_after.state", 32'(state_o), 4);

        at_edge(c1 + 45);
        chk("scoreboard.pending", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
